// File: rtl/mdio_slave_regs.sv
// Clause-22 MDIO management slave with a local 16-bit register file and a local update port.
// Optional: define MDIO_PREAMBLE_SUPPRESS_EN to accept a frame start after a single preamble one.
module mdio_slave_regs #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] RO_MASK  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        usr_we,
    input  logic [4:0]  usr_addr,
    input  logic [15:0] usr_wdata,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0] PRE_MIN = 6'd1;
`else
    localparam logic [5:0] PRE_MIN = 6'd32;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    function automatic logic addr_impl(input logic [4:0] a);
        return ({27'd0, a} < 32'(NUM_REGS));
    endfunction

    logic        mdc_q1_r, mdc_q2_r, mdc_q3_r;
    logic        mdio_q1_r, mdio_q2_r, mdio_d_r;
    state_t      state_r, state_s;
    logic [5:0]  pre_cnt_r, pre_cnt_s;
    logic [3:0]  bit_cnt_r, bit_cnt_s;
    logic [14:0] sh_r;
    logic        is_read_r, is_read_s;
    logic        phy_match_r, phy_match_s;
    logic [4:0]  regad_r, regad_s;
    logic        err_s, latch_rd_s, start_rd_s, commit_s;
    logic        rise_s, fall_s;
    logic [15:0] field_s;
    logic [15:0] rd_mux_s;
    logic [15:0] regs_r [NUM_REGS];
    logic [15:0] drv_sh_r;
    logic        drv_act_r;
    logic [4:0]  drv_cnt_r;
    logic        mdio_o_r, mdio_oe_r, wr_stb_r, frame_err_r;
    logic [4:0]  wr_addr_r;
    logic [15:0] wr_data_r;

    assign rise_s  = mdc_q2_r & ~mdc_q3_r;
    assign fall_s  = ~mdc_q2_r & mdc_q3_r;
    assign field_s = {sh_r, mdio_d_r};

    // Synchronisers for mdc and mdio plus the extra mdio delay stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {mdc_q1_r, mdc_q2_r, mdc_q3_r}   <= 3'b000;
            {mdio_q1_r, mdio_q2_r, mdio_d_r} <= 3'b000;
        end else begin
            {mdc_q1_r, mdc_q2_r, mdc_q3_r}   <= {mdc, mdc_q1_r, mdc_q2_r};
            {mdio_q1_r, mdio_q2_r, mdio_d_r} <= {mdio_i, mdio_q1_r, mdio_q2_r};
        end
    end

    // Frame decoder next-state and per-rise events.
    always_comb begin
        state_s     = state_r;
        pre_cnt_s   = pre_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        is_read_s   = is_read_r;
        phy_match_s = phy_match_r;
        regad_s     = regad_r;
        err_s       = 1'b0;
        latch_rd_s  = 1'b0;
        start_rd_s  = 1'b0;
        commit_s    = 1'b0;
        if (rise_s) begin
            case (state_r)
                S_IDLE: begin
                    if (mdio_d_r) begin
                        pre_cnt_s = (pre_cnt_r == 6'd32) ? pre_cnt_r : pre_cnt_r + 6'd1;
                    end else if (pre_cnt_r >= PRE_MIN) begin
                        state_s   = S_ST1;
                        pre_cnt_s = 6'd0;
                    end else begin
                        pre_cnt_s = 6'd0;
                    end
                end
                S_ST1: begin
                    bit_cnt_s = 4'd0;
                    if (mdio_d_r) begin
                        state_s = S_OP;
                    end else begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                    end
                end
                S_OP: begin
                    if (bit_cnt_r == 4'd0) begin
                        bit_cnt_s = 4'd1;
                    end else if (field_s[1:0] == 2'b10 || field_s[1:0] == 2'b01) begin
                        is_read_s = field_s[1];
                        bit_cnt_s = 4'd0;
                        state_s   = S_PHYAD;
                    end else begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                    end
                end
                S_PHYAD: begin
                    if (bit_cnt_r == 4'd4) begin
                        phy_match_s = (field_s[4:0] == PHY_ADDR);
                        bit_cnt_s   = 4'd0;
                        state_s     = S_REGAD;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end
                S_REGAD: begin
                    if (bit_cnt_r == 4'd4) begin
                        regad_s    = field_s[4:0];
                        latch_rd_s = 1'b1;
                        bit_cnt_s  = 4'd0;
                        state_s    = S_TA;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt_r == 4'd0) begin
                        bit_cnt_s  = 4'd1;
                        start_rd_s = is_read_r & phy_match_r;
                    end else if (!is_read_r && phy_match_r && field_s[1:0] != 2'b10) begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        bit_cnt_s = 4'd0;
                        state_s   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_cnt_r == 4'd15) begin
                        // A write that lands on an unimplemented or read-only address is dropped.
                        commit_s = ~is_read_r & phy_match_r & addr_impl(regad_r) & ~RO_MASK[regad_r];
                        state_s  = S_IDLE;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_s   = S_IDLE;
                    pre_cnt_s = 6'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Frame decoder state registers and bit shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            pre_cnt_r   <= 6'd0;
            bit_cnt_r   <= 4'd0;
            sh_r        <= 15'd0;
            is_read_r   <= 1'b0;
            phy_match_r <= 1'b0;
            regad_r     <= 5'd0;
        end else begin
            state_r     <= state_s;
            pre_cnt_r   <= pre_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            is_read_r   <= is_read_s;
            phy_match_r <= phy_match_s;
            regad_r     <= regad_s;
            if (rise_s) begin
                sh_r <= field_s[14:0];
            end
        end
    end

    // Read mux; unimplemented addresses read as all ones.
    always_comb begin
        rd_mux_s = 16'hFFFF;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_mux_s = (field_s[4:0] == 5'(i)) ? regs_r[i] : rd_mux_s;
        end
    end

    // Read-response driver: turnaround zero, 16 data bits, then release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drv_sh_r  <= 16'd0;
            drv_act_r <= 1'b0;
            drv_cnt_r <= 5'd0;
            mdio_o_r  <= 1'b0;
            mdio_oe_r <= 1'b0;
        end else begin
            if (latch_rd_s) begin
                drv_sh_r <= rd_mux_s;
            end
            if (start_rd_s) begin
                drv_act_r <= 1'b1;
                drv_cnt_r <= 5'd0;
            end else if (fall_s && drv_act_r) begin
                drv_cnt_r <= drv_cnt_r + 5'd1;
                if (drv_cnt_r == 5'd0) begin
                    mdio_oe_r <= 1'b1;
                    mdio_o_r  <= 1'b0;
                end else if (drv_cnt_r == 5'd17) begin
                    mdio_oe_r <= 1'b0;
                    mdio_o_r  <= 1'b0;
                    drv_act_r <= 1'b0;
                end else begin
                    mdio_o_r <= drv_sh_r[15];
                    drv_sh_r <= {drv_sh_r[14:0], 1'b0};
                end
            end
        end
    end

    // Register file; the local port overrides a simultaneous MDIO commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {8'(i + 1), 8'(i)};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (usr_we && usr_addr == 5'(i)) begin
                    regs_r[i] <= usr_wdata;
                end else if (commit_s && regad_r == 5'(i)) begin
                    regs_r[i] <= field_s;
                end
            end
        end
    end

    // Commit strobe and framing error outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_stb_r    <= 1'b0;
            wr_addr_r   <= 5'd0;
            wr_data_r   <= 16'd0;
            frame_err_r <= 1'b0;
        end else begin
            wr_stb_r    <= commit_s;
            frame_err_r <= err_s;
            if (commit_s) begin
                wr_addr_r <= regad_r;
                wr_data_r <= field_s;
            end
        end
    end

    assign mdio_o    = mdio_o_r;
    assign mdio_oe   = mdio_oe_r;
    assign wr_stb    = wr_stb_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_mdio_slave_regs.sv
// Self-checking bench for mdio_slave_regs: directed frames plus randomized traffic against a register model.
module tb_mdio_slave_regs;
    localparam int          NREGS = 16;
    localparam logic [31:0] RO    = 32'h0000_0004;

    logic        clk = 1'b0, reset = 1'b1, mdc = 1'b0, mdio_m = 1'b1;
    logic        usr_we = 1'b0;
    logic [4:0]  usr_addr = 5'd0;
    logic [15:0] usr_wdata = 16'd0;
    logic        mdio_i, mdio_o, mdio_oe, wr_stb, frame_err;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int tests = 0, fails = 0;
    int stb_cnt = 0, err_cnt = 0;
    logic [4:0]  last_addr = 5'd0;
    logic [15:0] last_data = 16'd0;
    logic [15:0] mregs [32];

    assign mdio_i = mdio_oe ? mdio_o : mdio_m;

    mdio_slave_regs #(.PHY_ADDR(5'd1), .NUM_REGS(NREGS), .RO_MASK(RO)) dut (
        .clk(clk), .reset(reset), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o),
        .mdio_oe(mdio_oe), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_cnt   <= stb_cnt + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = {8'(i + 1), 8'(i)};
    endfunction

    function automatic logic [15:0] model_read(input logic [4:0] a);
        return (int'(a) < NREGS) ? mregs[a] : 16'hFFFF;
    endfunction

    // One MDIO frame as master; returns read data, oe-high cycle count and turnaround status.
    task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                         input int abort_bit, input bit collide,
                         output logic [15:0] rd, output int oe_n, output logic ta_ok);
        bit q[$];
        int hdr;
        logic s_oe, s_o;
        rd = 16'd0; oe_n = 0; ta_ok = 1'b0;
        for (int i = 0; i < npre; i++) q.push_back(1'b1);
        q.push_back(1'b0); q.push_back(1'b1); q.push_back(op[1]); q.push_back(op[0]);
        for (int k = 4; k >= 0; k--) q.push_back(phy[k]);
        for (int k = 4; k >= 0; k--) q.push_back(ra[k]);
        hdr = q.size();
        if (op == 2'b10) begin
            for (int i = 0; i < 20; i++) q.push_back(1'b1);
        end else begin
            q.push_back(ta[1]); q.push_back(ta[0]);
            for (int k = 15; k >= 0; k--) q.push_back(wd[k]);
            q.push_back(1'b1); q.push_back(1'b1);
        end
        @(negedge clk);
        for (int i = 0; i < q.size(); i++) begin
            mdio_m = q[i];
            #80;
            s_oe = mdio_oe; s_o = mdio_o;
            if (s_oe === 1'b1) oe_n++;
            if (i == hdr + 1) ta_ok = (s_oe === 1'b1) && (s_o === 1'b0);
            if (i >= hdr + 2 && i <= hdr + 17) rd[15 - (i - hdr - 2)] = s_o;
            if (abort_bit >= 0 && i == hdr + 2 + abort_bit) begin
                check("abort_oe_before", {31'd0, s_oe}, 32'd1);
                #3 reset = 1'b1;
                #1 check("abort_oe_async", {31'd0, mdio_oe}, 32'd0);
                #40 reset = 1'b0;
                mdc = 1'b0; mdio_m = 1'b1;
                model_reset();
                return;
            end
            if (collide && i == hdr + 17) begin
                usr_we = 1'b1; usr_addr = ra; usr_wdata = 16'hAAAA;
                mdc = 1'b1;
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    if (wr_stb === 1'b1) break;
                end
                usr_we = 1'b0;
                #40;
            end else begin
                mdc = 1'b1;
                #80;
            end
            mdc = 1'b0;
        end
        mdio_m = 1'b1;
    endtask

    task automatic do_read(input string tag, input logic [4:0] phy, input logic [4:0] ra,
                           input int npre, input bit answered);
        logic [15:0] rd; int oe_n; logic ta_ok;
        frame(npre, 2'b10, phy, ra, 2'b00, 16'h0, -1, 1'b0, rd, oe_n, ta_ok);
        if (answered) begin
            check({tag, "_data"}, {16'd0, rd}, {16'd0, model_read(ra)});
            check({tag, "_oe_cycles"}, oe_n, 32'd17);
            check({tag, "_ta_zero"}, {31'd0, ta_ok}, 32'd1);
        end else begin
            check({tag, "_no_oe"}, oe_n, 32'd0);
        end
    endtask

    task automatic do_write(input string tag, input logic [4:0] phy, input logic [4:0] ra,
                            input logic [1:0] ta, input logic [15:0] wd, input bit collide);
        logic [15:0] rd; int oe_n; logic ta_ok; int s0, e0; bit exp_c, exp_e;
        s0 = stb_cnt; e0 = err_cnt;
        exp_c = (phy == 5'd1) && (int'(ra) < NREGS) && !RO[ra] && (ta == 2'b10);
        exp_e = (phy == 5'd1) && (ta != 2'b10);
        frame(32, 2'b01, phy, ra, ta, wd, -1, collide, rd, oe_n, ta_ok);
        #100;
        check({tag, "_stb_count"}, stb_cnt - s0, exp_c ? 32'd1 : 32'd0);
        check({tag, "_err_count"}, err_cnt - e0, exp_e ? 32'd1 : 32'd0);
        if (exp_c) begin
            check({tag, "_wr_addr"}, {27'd0, last_addr}, {27'd0, ra});
            check({tag, "_wr_data"}, {16'd0, last_data}, {16'd0, wd});
            mregs[ra] = collide ? 16'hAAAA : wd;
        end
    endtask

    task automatic usr_write(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        usr_we = 1'b1; usr_addr = a; usr_wdata = d;
        @(negedge clk);
        usr_we = 1'b0;
        if (int'(a) < NREGS) mregs[a] = d;
    endtask

    initial begin
        logic [15:0] rd; int oe_n; logic ta_ok; int e0, s0;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_mdio_oe", {31'd0, mdio_oe}, 32'd0);
        check("rst_mdio_o", {31'd0, mdio_o}, 32'd0);
        check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        do_read("rd_reg3", 5'd1, 5'd3, 32, 1'b1);
        do_write("wr_reg5", 5'd1, 5'd5, 2'b10, 16'hBEEF, 1'b0);
        do_read("rd_reg5", 5'd1, 5'd5, 32, 1'b1);
        do_read("rd_phy2", 5'd2, 5'd3, 32, 1'b0);
        do_read("rd_unimpl20", 5'd1, 5'd20, 32, 1'b1);
        do_write("wr_unimpl20", 5'd1, 5'd20, 2'b10, 16'h1111, 1'b0);
        do_write("wr_ro2", 5'd1, 5'd2, 2'b10, 16'h1234, 1'b0);
        do_read("rd_ro2", 5'd1, 5'd2, 32, 1'b1);
        usr_write(5'd2, 16'hCAFE);
        usr_write(5'd20, 16'hDEAD);
        do_read("rd_usr2", 5'd1, 5'd2, 32, 1'b1);
        do_write("wr_collide7", 5'd1, 5'd7, 2'b10, 16'h5555, 1'b1);
        do_read("rd_collide7", 5'd1, 5'd7, 32, 1'b1);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        do_read("rd_pre1", 5'd1, 5'd3, 1, 1'b1);
`else
        do_read("rd_pre20", 5'd1, 5'd3, 20, 1'b0);
`endif
        e0 = err_cnt; s0 = stb_cnt;
        frame(32, 2'b11, 5'd0, 5'd0, 2'b00, 16'h0, -1, 1'b0, rd, oe_n, ta_ok);
        #100;
        check("op11_err_count", err_cnt - e0, 32'd1);
        check("op11_stb_count", stb_cnt - s0, 32'd0);
        do_write("wr_ta11", 5'd1, 5'd6, 2'b11, 16'h0000, 1'b0);
        do_read("rd_ta11_reg6", 5'd1, 5'd6, 32, 1'b1);

        for (int n = 0; n < 24; n++) begin
            logic [4:0] phy, ra;
            phy = ($urandom_range(0, 3) == 0) ? 5'd2 : 5'd1;
            ra  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                do_read("rnd_rd", phy, ra, 32, phy == 5'd1);
            else
                do_write("rnd_wr", phy, ra, 2'b10, 16'($urandom), 1'b0);
        end

        do_write("wr_reg3", 5'd1, 5'd3, 2'b10, 16'h7777, 1'b0);
        frame(32, 2'b10, 5'd1, 5'd3, 2'b00, 16'h0, 8, 1'b0, rd, oe_n, ta_ok);
        repeat (4) @(negedge clk);
        do_read("rd_after_reset3", 5'd1, 5'd3, 32, 1'b1);
        do_read("rd_after_reset5", 5'd1, 5'd5, 32, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdio_slave_regs.md
Name: mdio_slave_regs

Overview:
- Synthesizable, parametrised Clause-22 MDIO management slave with a local 16-bit register file.
- Oversamples MDC/MDIO on the system clock, decodes the frame, answers reads and commits writes. Frames not addressed to this PHY are ignored.
- Sits beside the MAC as the on-chip PHY-management target; the same block serves as a bench PHY model.
- Adds PHY-address matching, configurable depth, read-only masking, a local update port and error reporting.

Parameters:
- PHY_ADDR, 5'd1: PHY address this slave answers.
- NUM_REGS, 32: implemented registers, 1..32. Addresses >= NUM_REGS are unimplemented.
- RO_MASK, 32'h0: bit i set makes register i read-only from MDIO.

Ports:
- clk  in  1  system clock; must be >= 8x MDC frequency.
- reset  in  1  asynchronous, active-high.
- mdc  in  1  management clock, asynchronous to clk.
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO pad output value.
- mdio_oe  out  1  MDIO pad output enable.
- usr_we  in  1  local register write strobe.
- usr_addr  in  5  local write address.
- usr_wdata  in  16  local write data.
- wr_stb  out  1  one-clk pulse when an MDIO write commits.
- wr_addr  out  5  address of the committed write.
- wr_data  out  16  data of the committed write.
- frame_err  out  1  one-clk pulse on a framing error.

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset values:
  - mdio_o=0, mdio_oe=0, wr_stb=0, wr_addr=0, wr_data=0, frame_err=0; FSM in IDLE; preamble count 0.
  - Register i resets to {i+1 (8b), i (8b)}, e.g. reg 3 = 16'h0403.
- Input synchronisation:
  - mdc and mdio_i each pass through a 2-flop synchroniser; mdio is additionally delayed 1 clk.
  - An MDC rise (r) or fall (f) is detected on the synchronised copy.
  - On r, the FSM samples the delayed mdio. On f, it updates mdio_o/mdio_oe.
- FSM on r events:
  - IDLE: each 1 increments the preamble count, saturating at 32. A 0 with count >= 32 goes to ST1; a 0 with count < 32 clears the count.
  - ST1: expects 1, then goes to OP. Otherwise frame_err and return to IDLE.
  - OP: 2 bits, MSB first. 10 = read, 01 = write. 00 or 11 gives frame_err, then IDLE.
  - PHYAD: 5 bits, MSB first.
  - REGAD: 5 bits, MSB first.
  - TA: 2 bits.
  - DATA: 16 bits, MSB first, then IDLE with the count cleared.
- Address mismatch (PHYAD != PHY_ADDR): track the frame without driving mdio or committing; no error.
- Read, address matched:
  - Read data is latched on the r of the last REGAD bit. Addresses >= NUM_REGS return 16'hFFFF.
  - First f after the TA1 sample: mdio_oe=1, mdio_o=0.
  - Next 16 f events drive D15..D0.
  - Following f: mdio_oe=0, mdio_o=0.
  - TA bits received from the master are not checked.
- Write, address matched:
  - TA must sample 1 then 0; otherwise frame_err and the frame is discarded (return to IDLE).
  - On the r that samples D0: if addr < NUM_REGS and RO_MASK[addr]=0, the register updates on the next clk and wr_stb pulses for 1 clk with wr_addr/wr_data.
  - Otherwise the write is dropped silently and wr_stb does not pulse.
- Local port:
  - usr_we writes any implemented register, including read-only ones, on that clk. usr_addr >= NUM_REGS is ignored.
  - If it coincides with an MDIO commit to the same address, usr wins and wr_stb still pulses.
- mdio_oe is never 1 outside the 17-bit read-response window.
- Reset mid-frame:
  - mdio_oe drops immediately (asynchronously) and the FSM returns to IDLE.
  - Registers revert to their reset values.
- An MDC stall holds the FSM state indefinitely; there is no timeout.

Optional Feature:
- MDIO_PREAMBLE_SUPPRESS_EN
- Defined: a 0 in IDLE after at least one 1 is accepted as the start of a frame (preamble suppression).
- Undefined: 32 consecutive ones are required before a start is accepted, as above.

Test Plan:
- Read, default parameters: 32x1, 0110, phyad 00001, regad 00011 -> slave drives 0 then 16'h0403 MSB first; mdio_oe high for exactly 17 MDC cycles.
- Write: 32x1, 0101, phyad 00001, regad 00101, TA 10, data 16'hBEEF -> wr_stb pulses once with wr_addr=5, wr_data=BEEF; a subsequent read of reg 5 returns BEEF.
- Mismatch and unimplemented:
  - Read to phyad 00010 -> mdio_oe stays 0.
  - With NUM_REGS=16, read regad 20 -> returns 16'hFFFF.
  - With NUM_REGS=16, write regad 20 -> no wr_stb.
- RO and collision:
  - With RO_MASK[2]=1, MDIO write of 1234 to reg 2 -> value stays 16'h0302, no wr_stb.
  - usr_we to reg 7 with 16'hAAAA on the same clk as an MDIO commit of 5555 to reg 7 -> reg 7 = AAAA and wr_stb pulses.
- Errors:
  - Only 20 preamble ones -> frame ignored, no response.
  - Op 11 -> frame_err pulse.
  - Write with TA 11 -> frame_err pulse, register unchanged.
  - Reset asserted mid-read at D8 -> mdio_oe=0 immediately; reg 3 back to 0403.
  - With MDIO_PREAMBLE_SUPPRESS_EN, a read after 1 preamble bit is answered.
